serial_addsub_unit: RTL
=======================

// Module: serial_addsub_unit
// PURPOSE
//  Multi-cycle, digit-serial N-bit adder/subtractor for the ALU datapath.
//  - Processes DIGIT bits per clock, LSB first, so area scales with DIGIT rather than N.
//  - Takes a start/busy/done handshake and carries the carry/borrow chain across cycles in a register.
//  - Returns result, carry/borrow and zero flag; sits beside the combinational ALU ops for area-limited builds.
// PARAMETERS
//  N      4  operand/result width in bits; N >= 2
//  DIGIT  1  bits processed per cycle; 1 <= DIGIT <= N, N % DIGIT == 0
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only in IDLE or DONE
//  op      in   1      0 = add, 1 = subtract; latched with start
//  A       in   N      operand A; latched with start
//  B       in   N      operand B; latched with start
//  cin     in   1      initial carry-in (add) or borrow-in (sub); latched with start
//  busy    out  1      high while in RUN
//  done    out  1      one-cycle completion pulse
//  result  out  N      A+B+cin or A-B-cin, mod 2^N
//  cout    out  1      add: final carry; sub: final borrow (1 when A < B+cin, unsigned)
//  zero    out  1      result == 0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy, done, result, cout, zero = 0.
//  Operand, shift and count registers also clear on reset.
//  FSM states: IDLE, RUN, DONE.
//  - IDLE, start=1: latch A, B, op, cin into shift regs and carry reg; count=0; go to RUN.
//  - RUN, each edge: take DIGIT LSBs a_d, b_d.
//    - add: {c, s_d} = a_d + b_d + c.
//    - sub: s_d = a_d - b_d - c mod 2^DIGIT; c = borrow out.
//    - Shift s_d into result from the MSB side; shift operands right by DIGIT; count++.
//    - When count == N/DIGIT-1, go to DONE on that edge.
//  - DONE: done=1 for exactly one cycle.
//    - start=1 here latches new operands and goes to RUN (back-to-back).
//    - Otherwise go to IDLE.
//  Outputs:
//  - result, cout and zero are updated only on the edge that enters DONE.
//  - They hold until the next completion or reset; intermediate shifts stay in an internal register.
//  Latency: start sampled at edge E -> done high in the cycle after edge E+N/DIGIT.
//  - Throughput: one op per N/DIGIT cycles.
//  Boundaries:
//  - start while busy is ignored; no queueing.
//  - A/B/op/cin changes after the start edge have no effect.
//  - Reset mid-RUN aborts the op; no done pulse; next start behaves as the first after reset.
//  - DIGIT == N: single RUN cycle, fully parallel, same handshake.
//  - Carry/borrow arithmetic is unsigned modulo 2^N, with no saturation.
// CONFIGURATION
//  ADDSUB_SIGNED_FLAGS_EN defined:
//  - Adds output ports overflow (1b) and negative (1b), updated with result, reset 0.
//  - negative = result[N-1].
//  - overflow (2's complement): add: A[N-1]==B[N-1] && result[N-1]!=A[N-1];
//    sub: A[N-1]!=B[N-1] && result[N-1]!=A[N-1].
//  - cin is not included in the overflow sign test.
//  ADDSUB_SIGNED_FLAGS_EN undefined: ports and logic absent; all other behaviour identical.
// TESTING
//  1. N=4,D=1: add 7+9, cin=0 -> result=0, cout=1, zero=1; done 4 edges after start edge, busy 4 cycles.
//  2. N=4,D=1: sub 3-5, cin=0 -> result=4'hE, cout=1, zero=0; (flags) negative=1, overflow=0.
//  3. N=4,D=1, flags: add 7+1 -> result=8, cout=0, overflow=1, negative=1.
//  4. start again while busy, with A/B changed mid-op -> ignored; result still 4'hE from test 2.
//     Then back-to-back start in DONE -> next op runs with no IDLE cycle.
//  5. rst high at 2nd RUN cycle -> busy=0, done=0, result=0 immediately (async).
//     After release, add 2+2 -> result=4, done after 4 edges.
//  6. N=8,D=2: add 8'hFF+8'h01, cin=1 -> result=8'h01, cout=1; done 4 edges after start.
//     Sub 8'h00-8'h01 -> 8'hFF, cout=1.

Source files
------------

// File: rtl/serial_addsub_unit.sv
// Digit-serial N-bit adder/subtractor, LSB first, DIGIT bits per clock.
// Optional signed flags (overflow, negative) with `define ADDSUB_SIGNED_FLAGS_EN.
module serial_addsub_unit #(
   parameter int N     = 4,
   parameter int DIGIT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         op,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         cout,
   output logic         zero
`ifdef ADDSUB_SIGNED_FLAGS_EN
   ,
   output logic         overflow,
   output logic         negative
`endif
);

   localparam int STEPS = N / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state_q;
   logic [N-1:0]    a_q, b_q, acc_q;
   logic            op_q, c_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q, done_q, cout_q, zero_q;
   logic [N-1:0]    result_q;

   logic [DIGIT-1:0] a_dig, b_dig, s_dig;
   logic [DIGIT:0]   t;
   logic             c_d;
   logic [N-1:0]     acc_d;
   logic             load;

   always_comb begin
      a_dig = a_q[DIGIT-1:0];
      b_dig = b_q[DIGIT-1:0];
      if (op_q)
         t = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, c_q};
      else
         t = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, c_q};
      s_dig = t[DIGIT-1:0];
      // For subtract the extra bit is the sign of the digit difference, i.e. borrow.
      c_d   = t[DIGIT];
      acc_d = N'({s_dig, acc_q} >> DIGIT);
   end

   assign load = start && (state_q == IDLE || state_q == DONE);

`ifdef ADDSUB_SIGNED_FLAGS_EN
   logic sa_q, sb_q, ovf_q, neg_q, ovf_d;

   always_comb begin
      if (op_q)
         ovf_d = (sa_q != sb_q) && (acc_d[N-1] != sa_q);
      else
         ovf_d = (sa_q == sb_q) && (acc_d[N-1] != sa_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
         ovf_q <= 1'b0;
         neg_q <= 1'b0;
      end else if (load) begin
         sa_q <= A[N-1];
         sb_q <= B[N-1];
      end else if (state_q == RUN && cnt_q == LAST) begin
         ovf_q <= ovf_d;
         neg_q <= acc_d[N-1];
      end
   end

   assign overflow = ovf_q;
   assign negative = neg_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         op_q     <= 1'b0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else if (load) begin
         state_q <= RUN;
         a_q     <= A;
         b_q     <= B;
         op_q    <= op;
         c_q     <= cin;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               acc_q <= acc_d;
               c_q   <= c_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q  <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= acc_d;
                  cout_q   <= c_d;
                  zero_q   <= (acc_d == '0);
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
   assign zero   = zero_q;

endmodule
